// File: rtl/poisson_spike_encoder_if.sv
// Spike-event stream from the encoder to the neuron/NoC injection port.
// valid/ready: the producer raises spike_valid with spike_addr and holds both stable until it samples spike_ready high at a clock edge; the event transfers on that edge.
interface poisson_spike_encoder_if #(
    parameter int ADDR_W = 4
);
    logic              spike_valid;
    logic [ADDR_W-1:0] spike_addr;
    logic              spike_ready;

    modport master (
        output spike_valid,
        output spike_addr,
        input  spike_ready
    );

    modport slave (
        input  spike_valid,
        input  spike_addr,
        output spike_ready
    );
endinterface

// File: rtl/poisson_spike_encoder.sv
// Converts per-channel firing rates into Bernoulli spikes: each time step, every channel's
// rate is compared against one fresh LFSR word and a hit emits the channel index as an event.
module poisson_spike_encoder #(
    parameter int DSIZE  = 16,
    parameter int NUM_CH = 16,
    parameter int ADDR_W = 4
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                step_i,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DSIZE-1:0]    wr_dat_i,
    input  logic [DSIZE-1:0]    rand_dat_i,
    output logic                rd_rand_o,
    poisson_spike_encoder_if.master spike_if,
    output logic                busy_o,
    output logic                done_o,
    output logic [ADDR_W:0]     spike_cnt_o,
    output logic                overrun_o,
    output logic [1:0]          state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CH - 1);
    localparam logic [ADDR_W:0]   NUM_CH_W = (ADDR_W + 1)'(NUM_CH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q;
    logic [ADDR_W-1:0]   spike_addr_q;
    logic [ADDR_W:0]     spike_cnt_q;
    logic                overrun_q;
    logic [DSIZE-1:0]    rate_q [NUM_CH];

    logic hit;
    logic handshake;
    logic is_last;

    // Compare uses the registered rate, so a same-cycle write never affects it.
    assign hit       = (rand_dat_i < rate_q[idx_q]);
    assign handshake = (state_q == EMIT) && spike_if.spike_ready;
    assign is_last   = (idx_q == LAST_IDX);

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (step_i) state_d = SCAN;
            SCAN: begin
                if (hit)          state_d = EMIT;
                else if (is_last) state_d = DONE;
            end
            EMIT: begin
                if (handshake) state_d = is_last ? DONE : SCAN;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        rd_rand_o            = (state_q == SCAN);
        spike_if.spike_valid = (state_q == EMIT);
        spike_if.spike_addr  = spike_addr_q;
        busy_o               = (state_q != IDLE);
        done_o               = (state_q == DONE);
        spike_cnt_o          = spike_cnt_q;
        overrun_o            = overrun_q;
        state_dbg_o          = state_q;
    end

    // Scan index, captured spike address, per-step counter and overrun flag
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idx_q        <= '0;
            spike_addr_q <= '0;
            spike_cnt_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (step_i) begin
                        idx_q       <= '0;
                        spike_cnt_q <= '0;
                        overrun_q   <= 1'b0;
                    end
                end
                SCAN: begin
                    if (hit)           spike_addr_q <= idx_q;
                    else if (!is_last) idx_q        <= idx_q + 1'b1;
                end
                EMIT: begin
                    if (handshake) begin
                        spike_cnt_q <= spike_cnt_q + 1'b1;
                        if (!is_last) idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
            if (step_i && (state_q != IDLE)) overrun_q <= 1'b1;
        end
    end

    // Rate registers; out-of-range addresses are dropped
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < NUM_CH; i++) rate_q[i] <= '0;
        end else if (wr_en_i && ({1'b0, wr_addr_i} < NUM_CH_W)) begin
            rate_q[wr_addr_i] <= wr_dat_i;
        end
    end

endmodule

// File: tb/tb_poisson_spike_encoder.sv
// Bench for poisson_spike_encoder: a rate/word reference model feeds an expected queue that
// a negedge monitor drains against the spike stream and end-of-step status.
module tb_poisson_spike_encoder;
  localparam int DSIZE  = 16;
  localparam int NUM_CH = 16;
  localparam int ADDR_W = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n_i;
  logic              step_i;
  logic              wr_en_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DSIZE-1:0]  wr_dat_i;
  logic [DSIZE-1:0]  rand_dat_i;
  logic              rd_rand_o;
  logic              busy_o;
  logic              done_o;
  logic [ADDR_W:0]   spike_cnt_o;
  logic              overrun_o;
  logic [1:0]        state_dbg_o;

  poisson_spike_encoder_if #(.ADDR_W(ADDR_W)) spike_if ();

  poisson_spike_encoder #(.DSIZE(DSIZE), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n_i),
    .step_i      (step_i),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_dat_i    (wr_dat_i),
    .rand_dat_i  (rand_dat_i),
    .rd_rand_o   (rd_rand_o),
    .spike_if    (spike_if.master),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .spike_cnt_o (spike_cnt_o),
    .overrun_o   (overrun_o),
    .state_dbg_o (state_dbg_o)
  );

  // scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  logic [ADDR_W-1:0] exp_q[$];
  int                exp_cnt_q[$];
  logic [DSIZE-1:0]  rate_m [NUM_CH];
  logic [DSIZE-1:0]  words  [NUM_CH];
  int ptr       = 0;
  int hold_low  = 0;
  int ready_prob = 100;
  int done_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks: all inputs change 1ns after the rising edge
  task automatic tick();
    logic adv;
    @(negedge clk);
    adv = rd_rand_o;
    @(posedge clk);
    #1;
    if (adv && ptr < NUM_CH - 1) ptr++;
    rand_dat_i = words[ptr];
    if (hold_low > 0) begin
      spike_if.spike_ready = 1'b0;
      hold_low--;
    end else begin
      spike_if.spike_ready = ($urandom_range(1, 100) <= ready_prob);
    end
    step_i  = 1'b0;
    wr_en_i = 1'b0;
  endtask

  task automatic write_rate(input int a, input logic [DSIZE-1:0] v);
    wr_en_i   = 1'b1;
    wr_addr_i = ADDR_W'(a);
    wr_dat_i  = v;
    tick();
    rate_m[a] = v;
  endtask

  // Reference: channel ch draws words[ch] and fires when that word is below its rate.
  task automatic start_step();
    int n;
    n = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (words[ch] < rate_m[ch]) begin
        exp_q.push_back(ADDR_W'(ch));
        n++;
      end
    end
    exp_cnt_q.push_back(n);
    ptr        = 0;
    rand_dat_i = words[0];
    step_i     = 1'b1;
    tick();
  endtask

  task automatic wait_done();
    int start;
    int k;
    start = done_cnt;
    k = 0;
    while (done_cnt == start && k < 3000) begin
      tick();
      k++;
    end
    check("done_seen", 32'(done_cnt != start), 32'd1);
  endtask

  task automatic run_step();
    start_step();
    wait_done();
  endtask

  // monitor: pops expectations whenever the DUT presents an event or finishes a step
  int cyc = 0;
  int step_cyc = 0;
  int rd_cnt = 0;
  int stalls = 0;
  int exp_n;
  logic prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (!reset_n_i) begin
      prev_stall = 1'b0;
    end else begin
      cyc++;
      if (step_i && !busy_o) begin
        step_cyc = cyc;
        rd_cnt   = 0;
        stalls   = 0;
      end
      if (rd_rand_o) rd_cnt++;
      if (spike_if.spike_valid) begin
        check("rd_rand_in_emit", 32'(rd_rand_o), 32'd0);
        if (prev_stall) check("addr_hold", 32'(spike_if.spike_addr), 32'(prev_addr));
        prev_addr  = spike_if.spike_addr;
        prev_stall = !spike_if.spike_ready;
        if (!spike_if.spike_ready) begin
          stalls++;
        end else if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_spike: got addr %0d expected none", spike_if.spike_addr);
        end else begin
          check("spike_addr", 32'(spike_if.spike_addr), 32'(exp_q.pop_front()));
        end
      end else begin
        prev_stall = 1'b0;
      end
      if (done_o) begin
        exp_n = (exp_cnt_q.size() > 0) ? exp_cnt_q.pop_front() : -1;
        check("spike_cnt", 32'(spike_cnt_o), 32'(exp_n));
        check("missing_spikes", 32'(exp_q.size()), 32'd0);
        check("rd_rand_count", 32'(rd_cnt), 32'(NUM_CH));
        check("done_latency", 32'(cyc - step_cyc), 32'(1 + NUM_CH + exp_n + stalls));
        done_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // main stimulus
  initial begin
    reset_n_i  = 1'b0;
    step_i     = 1'b0;
    wr_en_i    = 1'b0;
    wr_addr_i  = '0;
    wr_dat_i   = '0;
    rand_dat_i = '0;
    spike_if.spike_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      rate_m[i] = '0;
      words[i]  = '0;
    end
    #1;
    check("rst_valid", 32'(spike_if.spike_valid), 32'd0);
    check("rst_addr", 32'(spike_if.spike_addr), 32'd0);
    check("rst_rd_rand", 32'(rd_rand_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_cnt", 32'(spike_cnt_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("rst_state", 32'(state_dbg_o), 32'd0);
    tick();
    tick();
    reset_n_i = 1'b1;
    tick();

    // all rates zero: no spikes
    run_step();

    // threshold on channel 3
    write_rate(3, 16'h8000);
    for (int i = 0; i < NUM_CH; i++) words[i] = 16'h7FFF;
    run_step();
    for (int i = 0; i < NUM_CH; i++) words[i] = 16'h8000;
    run_step();

    // every channel fires, channel 0 stalled three cycles
    for (int i = 0; i < NUM_CH; i++) write_rate(i, 16'hFFFF);
    for (int i = 0; i < NUM_CH; i++) words[i] = DSIZE'($urandom_range(0, 16'hFFFE));
    spike_if.spike_ready = 1'b0;
    hold_low = 4;
    run_step();

    // reset while a spike is pending
    for (int i = 0; i < NUM_CH; i++) words[i] = '0;
    spike_if.spike_ready = 1'b0;
    hold_low = 20;
    start_step();
    for (int k = 0; k < 50 && !spike_if.spike_valid; k++) tick();
    check("emit_reached", 32'(spike_if.spike_valid), 32'd1);
    reset_n_i = 1'b0;
    #1;
    check("abort_valid", 32'(spike_if.spike_valid), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_cnt", 32'(spike_cnt_o), 32'd0);
    exp_q.delete();
    exp_cnt_q.delete();
    for (int i = 0; i < NUM_CH; i++) rate_m[i] = '0;
    tick();
    tick();
    reset_n_i = 1'b1;
    hold_low = 0;
    tick();
    run_step();

    // rate write lands in the same cycle channel 5 is compared
    start_step();
    repeat (5) tick();
    wr_en_i   = 1'b1;
    wr_addr_i = ADDR_W'(5);
    wr_dat_i  = 16'hFFFF;
    tick();
    wait_done();
    rate_m[5] = 16'hFFFF;
    run_step();

    // second step while busy is ignored but flagged
    for (int i = 0; i < NUM_CH; i++) write_rate(i, DSIZE'($urandom_range(0, 16'hFFFF)));
    for (int i = 0; i < NUM_CH; i++) words[i] = DSIZE'($urandom_range(0, 16'hFFFE));
    ready_prob = 70;
    start_step();
    repeat (4) tick();
    step_i = 1'b1;
    tick();
    wait_done();
    tick();
    check("overrun_set", 32'(overrun_o), 32'd1);
    start_step();
    check("overrun_clear", 32'(overrun_o), 32'd0);
    wait_done();

    // randomized rates, words and back-pressure
    for (int s = 0; s < 25; s++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        case ($urandom_range(0, 3))
          0:       write_rate(i, 16'h0000);
          1:       write_rate(i, 16'hFFFF);
          default: write_rate(i, DSIZE'($urandom_range(0, 16'hFFFF)));
        endcase
        words[i] = DSIZE'($urandom_range(0, 16'hFFFE));
      end
      ready_prob = $urandom_range(30, 100);
      run_step();
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/poisson_spike_encoder.md
Name: poisson_spike_encoder

Overview:
- Consumes pseudo-random words from the neuron-side LFSR and converts per-channel firing rates into Bernoulli (Poisson-approximate) input spikes, once per time step.
- Sits between the LFSR (upstream) and the neuron/NoC spike-injection interface (downstream).
- Each time step, every channel's stored rate is compared against one fresh random word. A spike event (channel address) is emitted over a valid/ready handshake whenever rand < rate.

Parameters:
- DSIZE, 16, width of rate words and random words; must match the LFSR width.
- NUM_CH, 16, number of input channels (rate registers).
- ADDR_W, 4, channel index width; must satisfy 2^ADDR_W >= NUM_CH.

Ports:
- clk_i  in  1  single clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- step_i  in  1  time-step tick; one-cycle pulse starts a scan.
- wr_en_i  in  1  rate register write enable.
- wr_addr_i  in  ADDR_W  rate register index.
- wr_dat_i  in  DSIZE  rate value; 0 = never fire, all-ones = always fire.
- rand_dat_i  in  DSIZE  current LFSR word.
- rd_rand_o  out  1  advance the LFSR (drives its rd_rand_i).
- spike_valid_o  out  1  spike event valid.
- spike_addr_o  out  ADDR_W  channel index of the spike.
- spike_ready_i  in  1  downstream accepts the event.
- busy_o  out  1  scan in progress (state != IDLE).
- done_o  out  1  one-cycle pulse at end of scan.
- spike_cnt_o  out  ADDR_W+1  spikes emitted in the current/last step.
- overrun_o  out  1  sticky flag: step_i arrived while busy.

Behaviour:
- Reset (async, reset_n_i=0):
  - state=IDLE, idx=0, all rate registers=0.
  - All outputs 0: rd_rand_o, spike_valid_o, spike_addr_o, busy_o, done_o, spike_cnt_o, overrun_o.
- FSM states: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - step_i=1 at an edge -> SCAN, idx=0, spike_cnt_o=0, overrun_o=0.
- SCAN (one cycle per channel):
  - rd_rand_o=1 combinationally in every SCAN cycle, so exactly one random word is consumed per channel.
  - hit = (rand_dat_i < rate[idx]), unsigned compare.
  - hit=1: register spike_addr_o=idx, go to EMIT.
  - hit=0 and idx<NUM_CH-1: idx+1, stay in SCAN.
  - hit=0 and idx=NUM_CH-1: go to DONE.
- EMIT:
  - spike_valid_o=1; spike_addr_o is held stable until spike_valid_o && spike_ready_i.
  - rd_rand_o=0.
  - On handshake: spike_cnt_o+1; idx=NUM_CH-1 -> DONE, else idx+1 -> SCAN.
  - A handshake may occur in the first EMIT cycle, giving a minimum of 2 cycles per spiking channel.
- DONE: done_o=1 for exactly one cycle, then IDLE. busy_o=0 only in IDLE.
- Latency:
  - No spikes: step_i sampled at edge E0 -> done_o high in the cycle after edge E0+NUM_CH.
  - Each spike adds (1 + ready stall cycles).
- step_i while busy: ignored (no restart); sets overrun_o=1, cleared on the next accepted step.
- Rate writes:
  - Allowed at any time; take effect the cycle after the write edge.
  - A write to the channel being compared in the same cycle does not affect that compare (the old value is used).
  - A wr_addr_i >= NUM_CH write is dropped.
- Boundaries:
  - rate=0 never fires.
  - rate=all-ones always fires, because the XNOR LFSR never outputs all-ones.
  - spike_cnt_o saturates naturally at NUM_CH (its width holds NUM_CH).
- Reset mid-scan or mid-EMIT: immediate abort to IDLE. The pending spike is lost and spike_valid_o drops asynchronously.

Test Plan:
- Reset, all rates 0, pulse step_i, rand_dat_i=16'h0000 -> 16 cycles of rd_rand_o=1; no spike_valid_o; done_o at cycle 17 after step; spike_cnt_o=0.
- rate[3]=16'h8000, rand_dat_i=16'h7FFF, spike_ready_i=1 -> single spike, spike_addr_o=3; done_o at cycle 18; spike_cnt_o=1. Repeat with rand_dat_i=16'h8000 -> no spike.
- All rates=16'hFFFF, spike_ready_i low for 3 cycles on channel 0 -> spike_addr_o=0 held stable with valid high, rd_rand_o=0 while stalled; 16 spikes in order 0..15; spike_cnt_o=16.
- Second step_i pulse 5 cycles into a scan -> scan unaffected, one done_o, overrun_o=1; next accepted step_i clears overrun_o.
- Write rate[5]=16'hFFFF in the same cycle SCAN compares idx 5 (old rate 0) -> no spike this step; spike on idx 5 next step.
- Assert reset_n_i during EMIT -> spike_valid_o, busy_o and spike_cnt_o all 0 immediately; rates read back as 0 (a step with rand 0 yields no spikes).
